video_stream_writer: RTL and testbench
======================================

# video_stream_writer

Wishbone bridge between the video stream master of `hw_support` and the SDRAM framebuffer. It accepts single-word pixel writes on a Wishbone slave port and buffers each address/data pair in a small register FIFO. It then replays them as classic Wishbone writes toward `wshb_intercon`, offset by a framebuffer base address. It replaces the constant tie-offs on `wshb_if_stream` and gives `vga` real image content.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries, power of two, 2..64.
- `BASE_ADDR`, 32'h0000_0000: byte offset added to every forwarded address.

Ports:
- `sys_clk`  in  1  system clock, 100 MHz.
- `sys_rst`  in  1  reset, synchronous, active-high.
- `wshb_ifs`  `wshb_if.slave`  32-bit data: stream side. Uses `cyc`, `stb`, `we`, `adr`, `dat_ms`, `sel` in; drives `ack`, `err`, `rty`, `dat_sm`.
- `wshb_ifm`  `wshb_if.master`  32-bit data: SDRAM side. Drives `cyc`, `stb`, `we`, `adr`, `dat_ms`, `sel`, `cti`, `bte`; uses `ack`, `err` in.
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Slave request: `cyc & stb` sampled high at a rising edge.
- Write request (`we=1`):
  - FIFO not full (level<DEPTH) at that edge: push {`adr`, `dat_ms`, `sel`}; `ack`=1 for exactly the next cycle.
  - FIFO full: no push, no ack. The request stays pending and is accepted on the first edge where level<DEPTH.
- Pop and push in the same cycle while full: the push is still refused that cycle; it is accepted the following edge.
- `rty` is always 0. `dat_sm` is always 0.
- Master FSM, two states:
  - IDLE: `cyc`=`stb`=0. Go to WRITE when level>0.
  - WRITE: `cyc`=`stb`=`we`=1, `cti`=3'b000, `bte`=2'b00.
    - `adr` = head.adr + BASE_ADDR, mod 2^32. `dat_ms`/`sel` = head fields.
    - Outputs are held stable until `ack|err` is sampled.
    - On `ack|err`: pop. If level after pop >0, stay in WRITE and present the next head on the next cycle (back-to-back). Otherwise go to IDLE.
  - `err` completes the transfer; the word is dropped.
- FIFO: register array, combinational head read, separate read/write pointers wrapping mod DEPTH. The level counter follows +1 on push, -1 on pop, unchanged on both.
- Reset, including mid-transfer: FIFO emptied, pointers 0, FSM to IDLE. All outputs 0: `ack`, `err`, `cyc`, `stb`, `we`, `adr`, `dat_ms`, `sel`, `fifo_level`. A master transfer in flight is abandoned, with no pop and no retry.

## Timing
- Slave ack latency: 1 cycle after the accepting edge. Ack is registered. Max throughput on the slave side is one write per 2 cycles, because the master drops `stb` after ack.
- Push to master `stb`: 1 cycle. The word pushed at edge N appears on `wshb_ifm` after edge N+1 when the FIFO was empty and the FSM was IDLE.
- Master side: one word per cycle while the SDRAM acks every cycle.
- `fifo_level` is registered and updates at the same edge as the push or pop.

## Configuration
- Macro `STREAM_WRITER_READ_ERR_EN`.
- Defined: a slave request with `we=0` gets `err`=1 for one cycle, one cycle after sampling. No push, no `ack`.
- Undefined: a slave read gets `ack`=1 for one cycle with `dat_sm`=0. No push, no `err`.
- Write behaviour is identical in both builds.

## Test plan
- Reset mid-transfer: assert `sys_rst` during a WRITE with 3 words queued -> next cycle `cyc`=0, `fifo_level`=0. After release, no stale word is emitted.
- Single write: slave adr=0x10, dat=0xA5A5_0001, BASE_ADDR=0x100, SDRAM ack after 3 cycles -> slave `ack` one cycle later. Master shows `adr`=0x110, `dat_ms`=0xA5A5_0001, `sel`=4'hF, held 3 cycles, then IDLE.
- Back-pressure: SDRAM ack held low, 10 writes offered with DEPTH=8 -> 8 acks, `fifo_level`=8, 9th request stalls. Release ack -> all 10 words arrive at SDRAM in order with correct addresses.
- Back-to-back drain: 4 queued words, SDRAM acks every cycle -> `stb` high for 4 consecutive cycles with 4 distinct addresses, then IDLE.
- Error path: SDRAM `err` on word 2 of 3 -> words 1 and 3 are written, word 2 is dropped, `fifo_level` returns to 0.
- Read handling: slave read request -> with `STREAM_WRITER_READ_ERR_EN`, `err`=1 for 1 cycle. Without it, `ack`=1 with `dat_sm`=0. `fifo_level` unchanged in both builds.

Source files
------------

// File: rtl/video_stream_writer.sv
// video_stream_writer: queues slave pixel writes in a DEPTH-entry FIFO, replays them as classic Wishbone writes at BASE_ADDR+adr.
// Slave ack 1 cycle after accept, requests stall while full; `STREAM_WRITER_READ_ERR_EN makes slave reads answer err instead of ack.
module video_stream_writer #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  // stream side (slave)
  input  logic                     wshb_ifs_cyc,
  input  logic                     wshb_ifs_stb,
  input  logic                     wshb_ifs_we,
  input  logic [31:0]              wshb_ifs_adr,
  input  logic [31:0]              wshb_ifs_dat_ms,
  input  logic [3:0]               wshb_ifs_sel,
  output logic                     wshb_ifs_ack,
  output logic                     wshb_ifs_err,
  output logic                     wshb_ifs_rty,
  output logic [31:0]              wshb_ifs_dat_sm,
  // SDRAM side (master)
  output logic                     wshb_ifm_cyc,
  output logic                     wshb_ifm_stb,
  output logic                     wshb_ifm_we,
  output logic [31:0]              wshb_ifm_adr,
  output logic [31:0]              wshb_ifm_dat_ms,
  output logic [3:0]               wshb_ifm_sel,
  output logic [2:0]               wshb_ifm_cti,
  output logic [1:0]               wshb_ifm_bte,
  input  logic                     wshb_ifm_ack,
  input  logic                     wshb_ifm_err,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [31:0]   r_fifo_adr [DEPTH];
  logic [31:0]   r_fifo_dat [DEPTH];
  logic [3:0]    r_fifo_sel [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_nxt;
  logic          r_ack;
  logic          r_err;

  logic          w_req;
  logic          w_full;
  logic          w_push;
  logic          w_rd;
  logic          w_rd_ack;
  logic          w_rd_err;
  logic          w_pop;

  // A request still showing our previous response is the one just answered, not a new one.
  assign w_req  = wshb_ifs_cyc & wshb_ifs_stb & ~r_ack & ~r_err;
  assign w_full = (r_level == LW'(DEPTH));
  assign w_push = w_req & wshb_ifs_we & ~w_full;
  assign w_rd   = w_req & ~wshb_ifs_we;
  assign w_pop  = (r_state == S_WRITE) & (wshb_ifm_ack | wshb_ifm_err);

`ifdef STREAM_WRITER_READ_ERR_EN
  assign w_rd_ack = 1'b0;
  assign w_rd_err = w_rd;
`else
  assign w_rd_ack = w_rd;
  assign w_rd_err = 1'b0;
`endif

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= w_level_nxt;
      r_ack   <= w_push | w_rd_ack;
      r_err   <= w_rd_err;
    end
  end

  // Payload storage carries no reset; the pointers and level define what is valid.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_fifo_adr[r_wptr] <= wshb_ifs_adr;
      r_fifo_dat[r_wptr] <= wshb_ifs_dat_ms;
      r_fifo_sel[r_wptr] <= wshb_ifs_sel;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    wshb_ifm_cyc    = 1'b0;
    wshb_ifm_stb    = 1'b0;
    wshb_ifm_we     = 1'b0;
    wshb_ifm_adr    = 32'h0;
    wshb_ifm_dat_ms = 32'h0;
    wshb_ifm_sel    = 4'h0;
    wshb_ifm_cti    = 3'b000;
    wshb_ifm_bte    = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (r_level != '0) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        wshb_ifm_cyc    = 1'b1;
        wshb_ifm_stb    = 1'b1;
        wshb_ifm_we     = 1'b1;
        wshb_ifm_adr    = r_fifo_adr[r_rptr] + BASE_ADDR;
        wshb_ifm_dat_ms = r_fifo_dat[r_rptr];
        wshb_ifm_sel    = r_fifo_sel[r_rptr];
        if (w_pop && (w_level_nxt == '0)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign wshb_ifs_ack    = r_ack;
  assign wshb_ifs_err    = r_err;
  assign wshb_ifs_rty    = 1'b0;
  assign wshb_ifs_dat_sm = 32'h0;
  assign fifo_level      = r_level;

endmodule

// File: tb/tb_video_stream_writer.sv
// Randomized bench for video_stream_writer: slave-side driver, SDRAM responder and an in-order scoreboard of accepted writes.
`timescale 1ns/1ps
module tb_video_stream_writer;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat;
  logic [3:0]  s_sel;
  logic        s_ack, s_err, s_rty;
  logic [31:0] s_dat_sm;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;
  logic        m_ack, m_err;
  logic [3:0]  lvl;

  always #5 sys_clk = ~sys_clk;

  video_stream_writer #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wshb_ifs_cyc(s_cyc), .wshb_ifs_stb(s_stb), .wshb_ifs_we(s_we),
    .wshb_ifs_adr(s_adr), .wshb_ifs_dat_ms(s_dat), .wshb_ifs_sel(s_sel),
    .wshb_ifs_ack(s_ack), .wshb_ifs_err(s_err), .wshb_ifs_rty(s_rty),
    .wshb_ifs_dat_sm(s_dat_sm),
    .wshb_ifm_cyc(m_cyc), .wshb_ifm_stb(m_stb), .wshb_ifm_we(m_we),
    .wshb_ifm_adr(m_adr), .wshb_ifm_dat_ms(m_dat), .wshb_ifm_sel(m_sel),
    .wshb_ifm_cti(m_cti), .wshb_ifm_bte(m_bte),
    .wshb_ifm_ack(m_ack), .wshb_ifm_err(m_err),
    .fifo_level(lvl)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  wr_t q_exp[$];

  // SDRAM responder controls and statistics
  bit          hold = 1'b0;
  int          fixed_dly = 0;
  int          max_dly = 0;
  bit          err_rand = 1'b0;
  int          err_idx = -1;
  int          hs_count = 0;
  int          n_written = 0;
  int          n_dropped = 0;
  int          wait_cnt = 0;
  int          cur_dly = 0;
  int          hold_len = 0;
  int          last_hold = 0;
  logic [31:0] first_adr, first_dat, last_hs_adr;

  always @(negedge sys_clk) begin
    m_ack = 1'b0;
    m_err = 1'b0;
    if (sys_rst) begin
      wait_cnt = 0;
      hold_len = 0;
    end else if (m_cyc && m_stb) begin
      if (hold_len == 0) begin
        first_adr = m_adr;
        first_dat = m_dat;
        cur_dly   = (fixed_dly >= 0) ? fixed_dly : $urandom_range(0, max_dly);
      end else begin
        chk("m_hold_adr", m_adr, first_adr);
        chk("m_hold_dat", m_dat, first_dat);
      end
      hold_len++;
      if (!hold && wait_cnt >= cur_dly) begin
        if (q_exp.size() == 0) begin
          chk("m_unexpected_word", 1, 0);
        end else begin
          wr_t e;
          e = q_exp.pop_front();
          chk("m_adr", m_adr, e.adr);
          chk("m_dat", m_dat, e.dat);
          chk("m_sel", m_sel, e.sel);
          chk("m_we_cti_bte", {m_we, m_cti, m_bte}, 6'b1_000_00);
        end
        if (hs_count == err_idx || (err_rand && $urandom_range(0, 7) == 0)) begin
          m_err = 1'b1;
          n_dropped++;
        end else begin
          m_ack = 1'b1;
          n_written++;
        end
        last_hs_adr = m_adr;
        hs_count++;
        last_hold = hold_len;
        hold_len  = 0;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // slave-side driver
  int          last_lat;
  logic [31:0] last_dat_sm;

  task automatic slv_start(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge sys_clk);
    s_cyc = 1'b1; s_stb = 1'b1; s_we = we; s_adr = a; s_dat = d; s_sel = s;
  endtask

  // res: 0 no response within bound (request left pending), 1 ack, 2 err
  task automatic slv_wait(input int bound, output int res);
    res = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge sys_clk);
      if (s_ack)      res = 1;
      else if (s_err) res = 2;
      if (res != 0) begin
        last_lat    = i;
        last_dat_sm = s_dat_sm;
        if (res == 1 && s_we) q_exp.push_back('{adr: s_adr + BASE, dat: s_dat, sel: s_sel});
        s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0;
        break;
      end
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int res);
    slv_start(1'b1, a, d, s);
    slv_wait(40, res);
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int k;
    k = 0;
    while ((q_exp.size() != 0 || m_stb) && k < bound) begin
      @(negedge sys_clk);
      k++;
    end
    chk({tag, "_drain_timeout"}, (k >= bound), 0);
    @(negedge sys_clk);
    chk({tag, "_level0"}, lvl, 0);
  endtask

  int          res, hs0, wr0, dr0, run;
  logic [31:0] prev_adr;
  bit          distinct;
  int          rd_exp;

  initial begin
`ifdef STREAM_WRITER_READ_ERR_EN
    rd_exp = 2;
`else
    rd_exp = 1;
`endif
    sys_rst = 1'b1;
    s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0; s_adr = '0; s_dat = '0; s_sel = '0;
    m_ack = 1'b0; m_err = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_outputs", {s_ack, s_err, s_rty, m_cyc, m_stb, m_we}, 6'b0);
    chk("rst_bus", {m_adr, m_dat, m_sel, s_dat_sm}, 100'h0);
    chk("rst_level", lvl, 0);
    sys_rst = 1'b0;

    // single write, SDRAM acks on the third cycle
    fixed_dly = 2;
    hs0 = hs_count;
    wr(32'h10, 32'hA5A5_0001, 4'hF, res);
    chk("t1_ack", res, 1);
    chk("t1_ack_latency", last_lat, 1);
    chk("t1_stb_not_yet", m_stb, 0);
    @(negedge sys_clk);
    chk("t1_stb_after_1", m_stb, 1);
    chk("t1_adr_direct", m_adr, 32'h110);
    wait_drain("t1", 20);
    chk("t1_hs", hs_count - hs0, 1);
    chk("t1_hold_cycles", last_hold, 3);
    chk("t1_idle", m_cyc, 0);

    // back-pressure: SDRAM stalled, 8 fit, 9th stalls
    hold = 1'b1;
    fixed_dly = 0;
    for (int i = 0; i < DEPTH; i++) begin
      wr(32'h1000 + i * 4, 32'hB000_0000 + i, 4'hF, res);
      chk("t2_accept", res, 1);
    end
    chk("t2_level_full", lvl, DEPTH);
    slv_start(1'b1, 32'h1020, 32'hB000_0008, 4'h3);
    slv_wait(8, res);
    chk("t2_ninth_stalls", res, 0);
    chk("t2_level_still_full", lvl, DEPTH);
    hold = 1'b0;
    slv_wait(40, res);
    chk("t2_ninth_accepted", res, 1);
    wr(32'h1024, 32'hB000_0009, 4'hC, res);
    chk("t2_tenth", res, 1);
    wait_drain("t2", 100);

    // back-to-back drain of 4 queued words
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr(32'h2000 + i * 4, $urandom, 4'hF, res);
      chk("t3_accept", res, 1);
    end
    chk("t3_level", lvl, 4);
    @(posedge sys_clk);
    #2 hold = 1'b0;
    run = 0; distinct = 1'b1; prev_adr = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (m_stb) begin
        if (run > 0 && m_adr == prev_adr) distinct = 1'b0;
        prev_adr = m_adr;
        run++;
      end else if (run > 0) begin
        break;
      end
    end
    chk("t3_stb_run", run, 4);
    chk("t3_distinct_adr", distinct, 1);
    wait_drain("t3", 20);

    // error on word 2 of 3
    hold = 1'b1;
    fixed_dly = 1;
    wr0 = n_written; dr0 = n_dropped;
    err_idx = hs_count + 1;
    for (int i = 0; i < 3; i++) begin
      wr(32'h3000 + i * 4, 32'hC000_0000 + i, 4'hF, res);
      chk("t4_accept", res, 1);
    end
    hold = 1'b0;
    wait_drain("t4", 40);
    chk("t4_written", n_written - wr0, 2);
    chk("t4_dropped", n_dropped - dr0, 1);
    err_idx = -1;

    // slave read while words are queued
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr(32'h4000 + i * 4, $urandom, 4'hF, res);
      chk("t5_accept", res, 1);
    end
    slv_start(1'b0, 32'h4000, 32'h0, 4'hF);
    slv_wait(10, res);
    chk("t5_read_resp", res, rd_exp);
    chk("t5_read_lat", last_lat, 1);
    chk("t5_dat_sm", last_dat_sm, 0);
    @(negedge sys_clk);
    chk("t5_level", lvl, 2);
    chk("t5_resp_single", {s_ack, s_err}, 2'b00);
    hold = 1'b0;
    wait_drain("t5", 40);

    // reset during a WRITE with 3 words queued
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr(32'h5000 + i * 4, $urandom, 4'hF, res);
      chk("t6_accept", res, 1);
    end
    @(negedge sys_clk);
    chk("t6_in_write", m_stb, 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("t6_cyc_after_rst", m_cyc, 0);
    chk("t6_level_after_rst", lvl, 0);
    sys_rst = 1'b0;
    q_exp.delete();
    hold = 1'b0;
    hs0 = hs_count;
    repeat (15) @(negedge sys_clk);
    chk("t6_no_stale_word", hs_count - hs0, 0);
    chk("t6_idle", m_cyc, 0);
    wr(32'h6000, 32'hD00D_0001, 4'h5, res);
    chk("t6_post_rst_accept", res, 1);
    wait_drain("t6", 20);

    // randomized mix with random SDRAM latency and errors
    fixed_dly = -1;
    max_dly = 3;
    err_rand = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 6) == 0) begin
        slv_start(1'b0, $urandom, $urandom, 4'hF);
        slv_wait(60, res);
        chk("rnd_read", res, rd_exp);
      end else begin
        wr($urandom, $urandom, 4'($urandom), res);
        chk("rnd_write", res, 1);
      end
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 12)) @(negedge sys_clk);
    end
    wait_drain("rnd", 400);
    chk("rnd_scoreboard_empty", q_exp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
